cd_host_comm: RTL and testbench
===============================

Name: cd_host_comm

Overview:
Host-side controller for the CD drive serial nibble link. It sits between the CD system registers (CPU side) and the CDD MCU model, and completes one full frame on each drive interrupt. A frame is 10 status nibbles read from the drive, followed by 10 command nibbles sent to it. The block generates the HOCK handshake, captures and checks the status frame, and appends the command checksum automatically.

Parameters:
SETTLE_CYCLES, 96, minimum CLK_12M cycles between any HOCK change and acting on a CDCK level (covers drive sample latency of 2 MCU ticks)
TIMEOUT_CYCLES, 4095, maximum CLK_12M cycles spent in any single wait state before the frame is aborted

Ports:
CLK_12M  in  1  system clock
RESET  in  1  asynchronous, active-high reset
CD_nIRQ  in  1  drive frame request, active low
CDCK  in  1  drive handshake strobe
CDD_DIN  in  4  nibble from drive
CDD_DOUT  out  4  nibble to drive
HOCK  out  1  host handshake strobe
CMD_DATA  in  36  command nibbles 0..8; nibble n is at bits [4n+3:4n]
STATUS_DATA  out  36  last accepted status nibbles 0..8, same packing
STATUS_VALID  out  1  one-cycle pulse when a frame completes and its status checksum is good
CHECKSUM_ERR  out  1  one-cycle pulse when a frame completes and its status checksum is bad
TIMEOUT  out  1  one-cycle pulse when a frame is aborted
BUSY  out  1  high while a frame is in progress

Behaviour:
- Reset values: HOCK=1, CDD_DOUT=0, STATUS_DATA=0, BUSY=0, all pulse outputs 0, state=IDLE, all counters 0. Reset asserted mid-frame returns to these values immediately, with no completion or timeout pulse.
- Edge detection: CD_nIRQ and CDCK are each registered once, and edges and levels are taken from the registered copies.
- IDLE: on a CD_nIRQ falling edge, latch CMD_DATA into the internal command buffer and compute cmd nibble 9 = ~(5 + sum of cmd nibbles 0..8) mod 16. Then set BUSY=1, HOCK=0, rd_cnt=0, and go to RD_WAITLO. Later changes to CMD_DATA do not affect the frame in progress.
- RD_WAITLO: wait SETTLE_CYCLES, then wait for CDCK==0. Capture CDD_DIN into stat[rd_cnt], set HOCK=1, go to RD_WAITHI.
- RD_WAITHI: wait for CDCK==1, then set HOCK=0 and go to RD_DROP.
- RD_DROP: wait SETTLE_CYCLES, then wait for CDCK==0.
  - If rd_cnt==9: wr_cnt=0, go to WR_SETUP.
  - Otherwise: rd_cnt+1, go to RD_WAITLO, whose settle dwell is already satisfied so it samples on the next cycle.
- WR_SETUP: drive CDD_DOUT = cmd[wr_cnt]. After 1 cycle of setup, set HOCK=1 and go to WR_WAITHI.
- WR_WAITHI: wait for CDCK==1, then set HOCK=0 and go to WR_WAITLO.
- WR_WAITLO: wait SETTLE_CYCLES, then wait for CDCK==0.
  - If wr_cnt==9: go to DONE.
  - Otherwise: wr_cnt+1, go to WR_SETUP.
- DONE (1 cycle): HOCK=1, BUSY=0.
  - Status check: good when stat[9] == ~(5 + sum stat[0..8]) mod 16, all sums 4-bit with wrap.
  - Good: copy stat[0..8] to STATUS_DATA and pulse STATUS_VALID.
  - Bad: pulse CHECKSUM_ERR; STATUS_DATA behaviour is set by the optional feature below.
  - Then go to IDLE.
- Timeout: the wait counter restarts on every state entry. If it reaches TIMEOUT_CYCLES in any wait state: HOCK=1, CDD_DOUT=0, BUSY=0, pulse TIMEOUT, go to IDLE. STATUS_DATA is unchanged.
- A CD_nIRQ falling edge while BUSY is ignored. A CD_nIRQ edge in the same cycle as DONE is also ignored; the drive re-asserts the request on its own.
- CDD_DOUT holds its last value after a completed frame.

Optional Feature:
Macro CDD_BAD_STATUS_HOLD_EN.
- Defined: a frame with a bad status checksum leaves STATUS_DATA unchanged.
- Undefined: a frame with a bad status checksum still copies stat[0..8] to STATUS_DATA, with CHECKSUM_ERR pulsed alongside. STATUS_VALID still pulses only on good frames.

Test Plan:
- Drive model sends status 0,0,0,0,0,0,0,0,0 with checksum A -> STATUS_VALID pulses once, STATUS_DATA=0, BUSY high for the whole frame, HOCK=1 afterwards.
- CMD_DATA nibbles 2,0,0,4,0,0,0,0,0 (TOC first/last) -> drive receives 2,0,0,4,0,0,0,0,0,4 and its 4-bit checksum sum equals F; next frame STATUS_DATA nibbles = 9,4,0,1,1,5,0,0,0.
- Status nibble 9 corrupted to 3 -> CHECKSUM_ERR pulses and STATUS_VALID does not. With macro defined STATUS_DATA keeps its prior value; without it STATUS_DATA takes the new nibbles.
- Drive model stops toggling CDCK after status nibble 4 -> after TIMEOUT_CYCLES (4095) cycles TIMEOUT pulses, HOCK=1, BUSY=0, STATUS_DATA unchanged; the next CD_nIRQ fall starts a clean frame.
- CMD_DATA changed mid-frame, plus a second CD_nIRQ fall while BUSY -> bytes sent match the value latched at frame start, and no second frame starts.
- RESET asserted during the write phase -> all outputs at reset values on the next edge; a frame after reset completes normally.

Source files
------------

// File: rtl/cd_host_comm.sv
// Host side of the CD drive nibble link: reads a 10-nibble status frame, then sends a
// 10-nibble command frame with auto checksum. Optional macro CDD_BAD_STATUS_HOLD_EN.
module cd_host_comm #(
  parameter int SETTLE_CYCLES  = 96,
  parameter int TIMEOUT_CYCLES = 4095
) (
  input  logic        CLK_12M,
  input  logic        RESET,
  input  logic        CD_nIRQ,
  input  logic        CDCK,
  input  logic [3:0]  CDD_DIN,
  output logic [3:0]  CDD_DOUT,
  output logic        HOCK,
  input  logic [35:0] CMD_DATA,
  output logic [35:0] STATUS_DATA,
  output logic        STATUS_VALID,
  output logic        CHECKSUM_ERR,
  output logic        TIMEOUT,
  output logic        BUSY
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] SETTLE_V = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] TMO_V    = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, RD_WAITLO, RD_WAITHI, RD_DROP, WR_SETUP, WR_WAITHI, WR_WAITLO, DONE
  } state_t;

  // Link checksum: nibble 9 = ~(5 + sum of nibbles 0..8), 4-bit wrap.
  function automatic logic [3:0] nib_cksum(input logic [35:0] nibs);
    logic [3:0] acc;
    acc = 4'd5;
    for (int i = 0; i < 9; i++) acc = acc + nibs[4*i +: 4];
    return ~acc;
  endfunction

  state_t           r_state, w_state;
  logic             r_irq_q, r_irq_q2, r_cdck_q;
  logic [CNT_W-1:0] r_wcnt, w_wcnt;
  logic [3:0]       r_rd_cnt, w_rd_cnt, r_wr_cnt, w_wr_cnt;
  logic             r_settled, w_settled;
  logic [39:0]      r_cmd, w_cmd, r_stat, w_stat;
  logic [3:0]       r_dout, w_dout;
  logic             r_hock, w_hock;
  logic [35:0]      r_status, w_status;
  logic             r_valid, w_valid, r_err, w_err, r_to, w_to, r_busy, w_busy;
  logic             w_abort;
  logic             w_irq_fall, w_settle_ok, w_tmo;

  assign w_irq_fall  = r_irq_q2 & ~r_irq_q;
  assign w_settle_ok = (r_wcnt >= SETTLE_V);
  assign w_tmo       = (r_wcnt == TMO_V);

  always_comb begin
    w_state   = r_state;
    w_wcnt    = r_wcnt + 1'b1;
    w_rd_cnt  = r_rd_cnt;
    w_wr_cnt  = r_wr_cnt;
    w_settled = r_settled;
    w_cmd     = r_cmd;
    w_stat    = r_stat;
    w_dout    = r_dout;
    w_hock    = r_hock;
    w_status  = r_status;
    w_valid   = 1'b0;
    w_err     = 1'b0;
    w_to      = 1'b0;
    w_busy    = r_busy;
    w_abort   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_irq_fall) begin
          w_cmd     = {nib_cksum(CMD_DATA), CMD_DATA};
          w_busy    = 1'b1;
          w_hock    = 1'b0;
          w_rd_cnt  = '0;
          w_settled = 1'b0;
          w_state   = RD_WAITLO;
        end
      end
      RD_WAITLO: begin
        // After the first nibble the settle dwell was already spent in RD_DROP.
        if ((w_settle_ok || r_settled) && !r_cdck_q) begin
          w_stat[{r_rd_cnt, 2'b00} +: 4] = CDD_DIN;
          w_hock  = 1'b1;
          w_state = RD_WAITHI;
        end else if (w_tmo) w_abort = 1'b1;
      end
      RD_WAITHI: begin
        if (r_cdck_q) begin
          w_hock  = 1'b0;
          w_state = RD_DROP;
        end else if (w_tmo) w_abort = 1'b1;
      end
      RD_DROP: begin
        if (w_settle_ok && !r_cdck_q) begin
          if (r_rd_cnt == 4'd9) begin
            w_wr_cnt = '0;
            w_state  = WR_SETUP;
          end else begin
            w_rd_cnt  = r_rd_cnt + 1'b1;
            w_settled = 1'b1;
            w_state   = RD_WAITLO;
          end
        end else if (w_tmo) w_abort = 1'b1;
      end
      WR_SETUP: begin
        // First cycle presents the nibble, second raises HOCK.
        w_dout = r_cmd[{r_wr_cnt, 2'b00} +: 4];
        if (r_wcnt != '0) begin
          w_hock  = 1'b1;
          w_state = WR_WAITHI;
        end
      end
      WR_WAITHI: begin
        if (r_cdck_q) begin
          w_hock  = 1'b0;
          w_state = WR_WAITLO;
        end else if (w_tmo) w_abort = 1'b1;
      end
      WR_WAITLO: begin
        if (w_settle_ok && !r_cdck_q) begin
          if (r_wr_cnt == 4'd9) w_state = DONE;
          else begin
            w_wr_cnt = r_wr_cnt + 1'b1;
            w_state  = WR_SETUP;
          end
        end else if (w_tmo) w_abort = 1'b1;
      end
      DONE: begin
        w_hock  = 1'b1;
        w_busy  = 1'b0;
        w_state = IDLE;
        if (r_stat[39:36] == nib_cksum(r_stat[35:0])) begin
          w_status = r_stat[35:0];
          w_valid  = 1'b1;
        end else begin
          w_err = 1'b1;
`ifdef CDD_BAD_STATUS_HOLD_EN
          w_status = r_status;
`else
          w_status = r_stat[35:0];
`endif
        end
      end
      default: w_state = IDLE;
    endcase
    if (w_abort) begin
      w_state = IDLE;
      w_hock  = 1'b1;
      w_dout  = '0;
      w_busy  = 1'b0;
      w_to    = 1'b1;
    end
    if (w_state != r_state || r_state == IDLE) w_wcnt = '0;
  end

  always_ff @(posedge CLK_12M or posedge RESET) begin
    if (RESET) begin
      r_state   <= IDLE;
      r_irq_q   <= 1'b1;
      r_irq_q2  <= 1'b1;
      r_cdck_q  <= 1'b1;
      r_wcnt    <= '0;
      r_rd_cnt  <= '0;
      r_wr_cnt  <= '0;
      r_settled <= 1'b0;
      r_cmd     <= '0;
      r_stat    <= '0;
      r_dout    <= '0;
      r_hock    <= 1'b1;
      r_status  <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      r_to      <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_irq_q   <= CD_nIRQ;
      r_irq_q2  <= r_irq_q;
      r_cdck_q  <= CDCK;
      r_wcnt    <= w_wcnt;
      r_rd_cnt  <= w_rd_cnt;
      r_wr_cnt  <= w_wr_cnt;
      r_settled <= w_settled;
      r_cmd     <= w_cmd;
      r_stat    <= w_stat;
      r_dout    <= w_dout;
      r_hock    <= w_hock;
      r_status  <= w_status;
      r_valid   <= w_valid;
      r_err     <= w_err;
      r_to      <= w_to;
      r_busy    <= w_busy;
    end
  end

  assign CDD_DOUT     = r_dout;
  assign HOCK         = r_hock;
  assign STATUS_DATA  = r_status;
  assign STATUS_VALID = r_valid;
  assign CHECKSUM_ERR = r_err;
  assign TIMEOUT      = r_to;
  assign BUSY         = r_busy;

endmodule

// File: tb/tb_cd_host_comm.sv
// Bench for cd_host_comm: a behavioural CDD drive model exchanges randomized frames and
// a frame-level reference model predicts command nibbles, status and pulses.
module tb_cd_host_comm;
  logic        CLK_12M = 1'b0;
  logic        RESET, CD_nIRQ, CDCK;
  logic [3:0]  CDD_DIN, CDD_DOUT;
  logic        HOCK;
  logic [35:0] CMD_DATA, STATUS_DATA;
  logic        STATUS_VALID, CHECKSUM_ERR, TIMEOUT, BUSY;

  always #5 CLK_12M = ~CLK_12M;

  cd_host_comm dut (
    .CLK_12M(CLK_12M), .RESET(RESET), .CD_nIRQ(CD_nIRQ), .CDCK(CDCK),
    .CDD_DIN(CDD_DIN), .CDD_DOUT(CDD_DOUT), .HOCK(HOCK), .CMD_DATA(CMD_DATA),
    .STATUS_DATA(STATUS_DATA), .STATUS_VALID(STATUS_VALID), .CHECKSUM_ERR(CHECKSUM_ERR),
    .TIMEOUT(TIMEOUT), .BUSY(BUSY)
  );

  int n_vec = 0, n_err = 0;
  int n_valid = 0, n_cerr = 0, n_to = 0;
  logic [3:0]  st_tx [10];
  logic [3:0]  rx [10];
  int          exp_nib [10];
  logic [35:0] model_status;
  bit          drv_ok;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge CLK_12M) begin
    if (STATUS_VALID === 1'b1) n_valid++;
    if (CHECKSUM_ERR === 1'b1) n_cerr++;
    if (TIMEOUT === 1'b1) n_to++;
  end

  initial begin
    #1500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_hock(input logic v);
    int n = 0;
    if (!drv_ok) return;
    while (HOCK !== v && n < 20000) begin
      @(negedge CLK_12M);
      n++;
    end
    if (HOCK !== v) drv_ok = 1'b0;
  endtask

  task automatic lat();
    repeat ($urandom_range(1, 8)) @(negedge CLK_12M);
  endtask

  task automatic rand_cmd();
    logic [63:0] r64;
    r64 = {$urandom(), $urandom()};
    CMD_DATA = r64[35:0];
  endtask

  // Drive side of one frame; stop_rd/glitch_rd/rst_wr select a scenario (-1 = off).
  task automatic drive_frame(input int stop_rd, input int glitch_rd, input int rst_wr);
    for (int i = 0; i < 10; i++) begin
      wait_hock(1'b0);
      lat();
      CDD_DIN = st_tx[i];
      CDCK    = 1'b0;
      if (i == glitch_rd) begin
        rand_cmd();
        CD_nIRQ = 1'b0;
        repeat (4) @(negedge CLK_12M);
        CD_nIRQ = 1'b1;
      end
      wait_hock(1'b1);
      if (i == stop_rd) return;
      if (i == 5) check_eq("busy_mid_read", 64'(BUSY), 64'(1));
      lat();
      CDCK = 1'b1;
    end
    wait_hock(1'b0);
    lat();
    CDCK = 1'b0;
    for (int j = 0; j < 10; j++) begin
      wait_hock(1'b1);
      lat();
      rx[j] = CDD_DOUT;
      if (j == rst_wr) return;
      if (j == 5) check_eq("busy_mid_write", 64'(BUSY), 64'(1));
      lat();
      CDCK = 1'b1;
      wait_hock(1'b0);
      lat();
      CDCK = 1'b0;
    end
    wait_hock(1'b1);
    lat();
    CDCK = 1'b1;
  endtask

  // Snapshot the command the host should send, then assert the frame request.
  task automatic start_frame();
    int s = 0;
    for (int n = 0; n < 9; n++) begin
      exp_nib[n] = int'(CMD_DATA[4*n +: 4]);
      s += exp_nib[n];
    end
    exp_nib[9] = 15 - ((5 + s) % 16);
    drv_ok  = 1'b1;
    CD_nIRQ = 1'b0;
    repeat (5) @(negedge CLK_12M);
    check_eq("busy_start", 64'(BUSY), 64'(1));
    check_eq("hock_start", 64'(HOCK), 64'(0));
    CD_nIRQ = 1'b1;
  endtask

  task automatic run_frame(input int glitch_rd);
    int v0, e0, t0, n, s, rs;
    bit good;
    v0 = n_valid; e0 = n_cerr; t0 = n_to;
    s = 0;
    for (int i = 0; i < 10; i++) s += int'(st_tx[i]);
    good = (((5 + s) % 16) == 15);
    start_frame();
    drive_frame(-1, glitch_rd, -1);
    n = 0;
    while (BUSY !== 1'b0 && n < 200) begin
      @(negedge CLK_12M);
      n++;
    end
    repeat (3) @(negedge CLK_12M);
    check_eq("drive_handshake", 64'(drv_ok), 64'(1));
    rs = 0;
    for (int j = 0; j < 10; j++) begin
      check_eq($sformatf("cmd_nib%0d", j), 64'(rx[j]), 64'(exp_nib[j]));
      rs += int'(rx[j]);
    end
    check_eq("cmd_sum", 64'((5 + rs) % 16), 64'(15));
`ifdef CDD_BAD_STATUS_HOLD_EN
    if (good) for (int i = 0; i < 9; i++) model_status[4*i +: 4] = st_tx[i];
`else
    for (int i = 0; i < 9; i++) model_status[4*i +: 4] = st_tx[i];
`endif
    check_eq("valid_pulses", 64'(n_valid - v0), 64'(good ? 1 : 0));
    check_eq("cerr_pulses", 64'(n_cerr - e0), 64'(good ? 0 : 1));
    check_eq("to_pulses", 64'(n_to - t0), 64'(0));
    check_eq("status_data", 64'(STATUS_DATA), 64'(model_status));
    check_eq("hock_after", 64'(HOCK), 64'(1));
    check_eq("busy_after", 64'(BUSY), 64'(0));
    check_eq("dout_hold", 64'(CDD_DOUT), 64'(exp_nib[9]));
  endtask

  task automatic rand_status(input bit make_bad);
    int s = 0;
    for (int i = 0; i < 9; i++) begin
      st_tx[i] = 4'($urandom_range(0, 15));
      s += int'(st_tx[i]);
    end
    st_tx[9] = 4'(15 - ((5 + s) % 16));
    if (make_bad) st_tx[9] = st_tx[9] + 4'($urandom_range(1, 15));
  endtask

  initial begin
    int v0, e0, t0, n;
    RESET = 1'b1; CD_nIRQ = 1'b1; CDCK = 1'b1; CDD_DIN = '0; CMD_DATA = '0;
    model_status = '0;
    drv_ok = 1'b1;
    repeat (3) @(negedge CLK_12M);
    check_eq("rst_hock", 64'(HOCK), 64'(1));
    check_eq("rst_dout", 64'(CDD_DOUT), 64'(0));
    check_eq("rst_status", 64'(STATUS_DATA), 64'(0));
    check_eq("rst_busy", 64'(BUSY), 64'(0));
    check_eq("rst_pulses", 64'({STATUS_VALID, CHECKSUM_ERR, TIMEOUT}), 64'(0));
    RESET = 1'b0;
    repeat (3) @(negedge CLK_12M);

    // All-zero status with checksum A.
    for (int i = 0; i < 9; i++) st_tx[i] = 4'h0;
    st_tx[9] = 4'hA;
    rand_cmd();
    run_frame(-1);

    // TOC command 2,0,0,4 and a known status frame.
    CMD_DATA = 36'h0_0000_4002;
    st_tx = '{4'h9, 4'h4, 4'h0, 4'h1, 4'h1, 4'h5, 4'h0, 4'h0, 4'h0, 4'h6};
    run_frame(-1);
    check_eq("toc_cksum", 64'(rx[9]), 64'(4));
    check_eq("toc_status", 64'(STATUS_DATA), 64'(36'h0_0051_1049));

    // Same status, checksum corrupted to 3.
    st_tx[9] = 4'h3;
    rand_cmd();
    run_frame(-1);

    for (int k = 0; k < 6; k++) begin
      rand_status($urandom_range(0, 3) == 0);
      rand_cmd();
      run_frame(-1);
    end

    // Drive stalls after status nibble 4; command checksum A leaves DOUT non-zero first.
    CMD_DATA = '0;
    rand_status(1'b0);
    run_frame(-1);
    v0 = n_valid; e0 = n_cerr; t0 = n_to;
    rand_status(1'b0);
    start_frame();
    drive_frame(4, -1, -1);
    check_eq("stall_handshake", 64'(drv_ok), 64'(1));
    n = 0;
    while (TIMEOUT !== 1'b1 && n < 6000) begin
      @(negedge CLK_12M);
      n++;
    end
    check_eq("to_latency_ok", 64'(n >= 4090 && n <= 4100), 64'(1));
    repeat (3) @(negedge CLK_12M);
    check_eq("to_pulse_cnt", 64'(n_to - t0), 64'(1));
    check_eq("to_no_valid", 64'((n_valid - v0) + (n_cerr - e0)), 64'(0));
    check_eq("to_hock", 64'(HOCK), 64'(1));
    check_eq("to_busy", 64'(BUSY), 64'(0));
    check_eq("to_dout", 64'(CDD_DOUT), 64'(0));
    check_eq("to_status", 64'(STATUS_DATA), 64'(model_status));
    CDCK = 1'b1;
    repeat (10) @(negedge CLK_12M);
    rand_status(1'b0);
    rand_cmd();
    run_frame(-1);

    // Command changes and a second request while busy.
    rand_status(1'b0);
    rand_cmd();
    run_frame(3);
    repeat (300) @(negedge CLK_12M);
    check_eq("no_second_busy", 64'(BUSY), 64'(0));
    check_eq("no_second_hock", 64'(HOCK), 64'(1));

    // Reset in the middle of the write phase.
    v0 = n_valid; e0 = n_cerr; t0 = n_to;
    rand_status(1'b0);
    rand_cmd();
    start_frame();
    drive_frame(-1, -1, 3);
    check_eq("pre_rst_handshake", 64'(drv_ok), 64'(1));
    RESET = 1'b1;
    #1;
    check_eq("mrst_hock", 64'(HOCK), 64'(1));
    check_eq("mrst_dout", 64'(CDD_DOUT), 64'(0));
    check_eq("mrst_busy", 64'(BUSY), 64'(0));
    check_eq("mrst_status", 64'(STATUS_DATA), 64'(0));
    @(negedge CLK_12M);
    RESET = 1'b0;
    CDCK = 1'b1;
    model_status = '0;
    repeat (10) @(negedge CLK_12M);
    check_eq("mrst_no_pulses", 64'((n_valid - v0) + (n_cerr - e0) + (n_to - t0)), 64'(0));
    rand_status(1'b0);
    rand_cmd();
    run_frame(-1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
